// File: rtl/get_pins_bank.sv
// Broadcasts one word into CHANNELS parallel DEPTH-stage register pipelines with per-channel input inversion.
// Latency: DEPTH enabled edges from data_in to data_out; fill_level/valid_out registered, no comb input->output path.
module get_pins_bank #(
    parameter int                  WIDTH    = 1,
    parameter int                  CHANNELS = 2,
    parameter int                  DEPTH    = 1,
    parameter logic [CHANNELS-1:0] INV_MASK = CHANNELS'(1),
    parameter int                  FW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          data_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [FW-1:0]             fill_level,
    output logic                      valid_out
);

    logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] st_q, st_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          valid_q, valid_d;

    always_comb begin
        st_d = st_q;
        if (en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_d[c][0] = data_in ^ {WIDTH{INV_MASK[c]}};
                for (int k = 1; k < DEPTH; k++) begin
                    st_d[c][k] = st_q[c][k-1];
                end
            end
        end
    end

    // Flush restarts fill tracking only; the word captured on a flush edge still counts.
    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = en ? FW'(1) : '0;
        end else if (en && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + FW'(1);
        end
        valid_d = (fill_d == FW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        data_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out[c*WIDTH +: WIDTH] = st_q[c][DEPTH-1];
        end
    end

    assign fill_level = fill_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_get_pins_bank.sv
// Directed bench for get_pins_bank: legacy defaults, 3x8-bit 4-deep pipeline with stall/flush/reset, and 3-deep saturation.
module tb_get_pins_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance 0: defaults (WIDTH=1, CHANNELS=2, DEPTH=1, INV_MASK=2'b01)
    logic       rst0, en0, flush0;
    logic [0:0] d0;
    logic [1:0] q0;
    logic [0:0] f0;
    logic       v0;

    get_pins_bank u0 (
        .clk(clk), .rst(rst0), .en(en0), .flush(flush0), .data_in(d0),
        .data_out(q0), .fill_level(f0), .valid_out(v0)
    );

    // Instance 1: WIDTH=8, CHANNELS=3, DEPTH=4, INV_MASK=3'b101
    logic        rst1, en1, flush1;
    logic [7:0]  d1;
    logic [23:0] q1;
    logic [2:0]  f1;
    logic        v1;

    get_pins_bank #(.WIDTH(8), .CHANNELS(3), .DEPTH(4), .INV_MASK(3'b101)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .flush(flush1), .data_in(d1),
        .data_out(q1), .fill_level(f1), .valid_out(v1)
    );

    // Instance 2: WIDTH=4, CHANNELS=2, DEPTH=3
    logic       rst2, en2, flush2;
    logic [3:0] d2;
    logic [7:0] q2;
    logic [1:0] f2;
    logic       v2;

    get_pins_bank #(.WIDTH(4), .CHANNELS(2), .DEPTH(3)) u2 (
        .clk(clk), .rst(rst2), .en(en2), .flush(flush2), .data_in(d2),
        .data_out(q2), .fill_level(f2), .valid_out(v2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [23:0] q, input logic [2:0] f, input logic v,
                        input logic [23:0] eq, input logic [2:0] ef, input logic ev);
        chk({tag, "_data"}, 64'(q), 64'(eq));
        chk({tag, "_fill"}, 64'(f), 64'(ef));
        chk({tag, "_valid"}, 64'(v), 64'(ev));
    endtask

    initial begin
        rst0 = 1'b1; en0 = 1'b1; flush0 = 1'b0; d0 = 1'b1;
        rst1 = 1'b1; en1 = 1'b1; flush1 = 1'b0; d1 = 8'hFF;
        rst2 = 1'b1; en2 = 1'b1; flush2 = 1'b0; d2 = 4'h5;
        #2;
        tick();
        tick();

        // Reset dominates en with nonzero input
        chk("rst0_data", 64'(q0), 64'h0);
        chk("rst0_fill", 64'(f0), 64'h0);
        chk("rst0_valid", 64'(v0), 64'h0);
        chk1("rst1", q1, f1, v1, 24'h0, 3'd0, 1'b0);
        chk("rst2_data", 64'(q2), 64'h0);

        // Legacy pairing: ch1 true, ch0 inverted
        rst0 = 1'b0; en0 = 1'b1; d0 = 1'b1;
        tick();
        chk("leg_d1_data", 64'(q0), 64'h2);
        chk("leg_d1_valid", 64'(v0), 64'h1);
        chk("leg_d1_fill", 64'(f0), 64'h1);
        d0 = 1'b0;
        tick();
        chk("leg_d0_data", 64'(q0), 64'h1);
        en0 = 1'b0; d0 = 1'b1;
        tick();
        chk("leg_stall_data", 64'(q0), 64'h1);
        chk("leg_stall_valid", 64'(v0), 64'h1);

        // Pipeline latency with a 2-cycle stall after 0x33
        rst1 = 1'b0; en1 = 1'b1; d1 = 8'h11;
        tick();
        chk1("pipe_e1", q1, f1, v1, 24'h0, 3'd1, 1'b0);
        d1 = 8'h22;
        tick();
        chk1("pipe_e2", q1, f1, v1, 24'h0, 3'd2, 1'b0);
        d1 = 8'h33;
        tick();
        chk1("pipe_e3", q1, f1, v1, 24'h0, 3'd3, 1'b0);
        en1 = 1'b0; d1 = 8'hA5;
        tick();
        chk1("pipe_stall1", q1, f1, v1, 24'h0, 3'd3, 1'b0);
        tick();
        chk1("pipe_stall2", q1, f1, v1, 24'h0, 3'd3, 1'b0);
        en1 = 1'b1; d1 = 8'h44;
        tick();
        chk1("pipe_e4", q1, f1, v1, 24'hEE11EE, 3'd4, 1'b1);
        d1 = 8'h55;
        tick();
        chk1("pipe_e5", q1, f1, v1, 24'hDD22DD, 3'd4, 1'b1);
        en1 = 1'b0; d1 = 8'h00;
        tick();
        chk1("pipe_hold", q1, f1, v1, 24'hDD22DD, 3'd4, 1'b1);

        // Flush: without enable clears fill only; with enable counts the capture
        flush1 = 1'b1; en1 = 1'b0;
        tick();
        chk1("flush_noen", q1, f1, v1, 24'hDD22DD, 3'd0, 1'b0);
        flush1 = 1'b1; en1 = 1'b1; d1 = 8'h66;
        tick();
        chk1("flush_en", q1, f1, v1, 24'hCC33CC, 3'd1, 1'b0);
        flush1 = 1'b0; d1 = 8'h77;
        tick();
        chk1("refill2", q1, f1, v1, 24'hBB44BB, 3'd2, 1'b0);
        d1 = 8'h88;
        tick();
        chk1("refill3", q1, f1, v1, 24'hAA55AA, 3'd3, 1'b0);
        d1 = 8'h99;
        tick();
        chk1("refill4", q1, f1, v1, 24'h996699, 3'd4, 1'b1);

        // Mid-stream reset at fill level 2
        flush1 = 1'b1; d1 = 8'hA0;
        tick();
        chk1("pre_rst1", q1, f1, v1, 24'h887788, 3'd1, 1'b0);
        flush1 = 1'b0; d1 = 8'hB0;
        tick();
        chk1("pre_rst2", q1, f1, v1, 24'h778877, 3'd2, 1'b0);
        rst1 = 1'b1; flush1 = 1'b1; en1 = 1'b1; d1 = 8'hFF;
        tick();
        chk1("mid_rst", q1, f1, v1, 24'h0, 3'd0, 1'b0);
        rst1 = 1'b0; flush1 = 1'b0; d1 = 8'hC1;
        tick();
        chk1("post_rst1", q1, f1, v1, 24'h0, 3'd1, 1'b0);
        d1 = 8'hC2;
        tick();
        chk1("post_rst2", q1, f1, v1, 24'h0, 3'd2, 1'b0);
        d1 = 8'hC3;
        tick();
        chk1("post_rst3", q1, f1, v1, 24'h0, 3'd3, 1'b0);
        d1 = 8'hC4;
        tick();
        chk1("post_rst4", q1, f1, v1, 24'h3EC13E, 3'd4, 1'b1);

        // Saturation at DEPTH=3 over 10 enabled edges
        rst2 = 1'b0; en2 = 1'b1; d2 = 4'h5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sat_fill_%0d", i), 64'(f2), 64'((i < 3) ? i : 3));
            chk($sformatf("sat_valid_%0d", i), 64'(v2), 64'(i >= 3));
        end
        chk("sat_data", 64'(q2), 64'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
